hazard_forward_unit: RTL and testbench



---
 rtl/hazard_forward_if.sv | 36 +++
 rtl/hazard_forward_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_if.sv
// Bundle between the pipeline control and the hazard/forwarding unit.
// The pipeline drives the master side and the hazard unit sits on the slave side.
interface hazard_forward_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  freeze;
  logic                  flush;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  is_single_src;
  logic                  is_BNE;
  logic [REG_ADDR_W-1:0] Exe_Dest;
  logic                  Exe_WB_EN;
  logic                  Exe_MEM_R_EN;
  logic [REG_ADDR_W-1:0] Mem_Dest;
  logic                  Mem_WB_EN;
  logic [REG_ADDR_W-1:0] WB_Dest;
  logic                  WB_WB_EN;
  logic                  hazard_Detected;
  logic [1:0]            fwd_sel_src1;
  logic [1:0]            fwd_sel_src2;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output freeze, flush, src1, src2, is_single_src, is_BNE,
           Exe_Dest, Exe_WB_EN, Exe_MEM_R_EN, Mem_Dest, Mem_WB_EN, WB_Dest, WB_WB_EN,
    input  hazard_Detected, fwd_sel_src1, fwd_sel_src2, stall_count
  );

  modport slave (
    input  freeze, flush, src1, src2, is_single_src, is_BNE,
           Exe_Dest, Exe_WB_EN, Exe_MEM_R_EN, Mem_Dest, Mem_WB_EN, WB_Dest, WB_WB_EN,
    output hazard_Detected, fwd_sel_src1, fwd_sel_src2, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection, multi-cycle load-use stall and EXE forwarding selects for the
// 5-stage MIPS pipeline, placed between ID and the ID/EXE register.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FORWARD_EN = 1,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_forward_if.slave  bus
);

  typedef enum logic {IDLE, LSTALL} state_t;

  localparam logic [3:0] REMAIN_LOAD = 4'(LOAD_STALL - 1);
  localparam bit         MULTI_STALL = (LOAD_STALL > 1);

  state_t                state, state_nxt;
  logic [3:0]            remain, remain_nxt;
  logic [REG_ADDR_W-1:0] exe_src1, exe_src2;
  logic                  exe_use2;
  logic [CNT_W-1:0]      stall_cnt;

  logic use2, m_e, m_m, load_use, det, hazard;

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] d,
                                     input logic                  en);
    return (r != '0) && (r == d) && en;
  endfunction

  always_comb begin
    use2     = bus.is_BNE | ~bus.is_single_src;
    m_e      = reg_match(bus.src1, bus.Exe_Dest, bus.Exe_WB_EN) |
               (use2 & reg_match(bus.src2, bus.Exe_Dest, bus.Exe_WB_EN));
    m_m      = reg_match(bus.src1, bus.Mem_Dest, bus.Mem_WB_EN) |
               (use2 & reg_match(bus.src2, bus.Mem_Dest, bus.Mem_WB_EN));
    load_use = m_e & bus.Exe_MEM_R_EN;
    if (FORWARD_EN == 0)
      det = m_e | m_m;
    else
      det = load_use | (bus.is_BNE & (m_e | m_m));
  end

  // ---- stall FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // ---- stall FSM: next state (a taken branch kills any pending stall) ----
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    if (bus.flush) begin
      state_nxt  = IDLE;
      remain_nxt = '0;
    end else if (!bus.freeze) begin
      case (state)
        IDLE: begin
          if (load_use && MULTI_STALL) begin
            state_nxt  = LSTALL;
            remain_nxt = REMAIN_LOAD;
          end
        end
        LSTALL: begin
          if (remain == 4'd1) begin
            state_nxt  = IDLE;
            remain_nxt = '0;
          end else begin
            remain_nxt = remain - 4'd1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          remain_nxt = '0;
        end
      endcase
    end
  end

  // ---- stall FSM: outputs (forced low while reset is held) ----
  always_comb begin
    hazard = rst & ~bus.flush & (det | (state == LSTALL));
  end

  // ---- ID -> EXE boundary: operand tracking, bubble on stall or flush ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_src1 <= '0;
      exe_src2 <= '0;
      exe_use2 <= 1'b0;
    end else if (!bus.freeze) begin
      if (bus.flush || hazard) begin
        exe_src1 <= '0;
        exe_src2 <= '0;
        exe_use2 <= 1'b0;
      end else begin
        exe_src1 <= bus.src1;
        exe_src2 <= bus.src2;
        exe_use2 <= use2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (hazard && !bus.freeze && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    bus.fwd_sel_src1 = 2'd0;
    bus.fwd_sel_src2 = 2'd0;
    if (FORWARD_EN != 0) begin
      if (reg_match(exe_src1, bus.Mem_Dest, bus.Mem_WB_EN))
        bus.fwd_sel_src1 = 2'd1;
      else if (reg_match(exe_src1, bus.WB_Dest, bus.WB_WB_EN))
        bus.fwd_sel_src1 = 2'd2;
      if (exe_use2) begin
        if (reg_match(exe_src2, bus.Mem_Dest, bus.Mem_WB_EN))
          bus.fwd_sel_src2 = 2'd1;
        else if (reg_match(exe_src2, bus.WB_Dest, bus.WB_WB_EN))
          bus.fwd_sel_src2 = 2'd2;
      end
    end
  end

  assign bus.hazard_Detected = hazard;
  assign bus.stall_count     = stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three parameterisations share one stimulus stream
// and are compared every cycle against a cycle-level reference model.
module tb_hazard_forward_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic freeze, flush, is_single_src, is_BNE;
  logic Exe_WB_EN, Exe_MEM_R_EN, Mem_WB_EN, WB_WB_EN;
  logic [AW-1:0] src1, src2, Exe_Dest, Mem_Dest, WB_Dest;

  hazard_forward_if #(.REG_ADDR_W(AW), .CNT_W(16)) hf0 ();
  hazard_forward_if #(.REG_ADDR_W(AW), .CNT_W(16)) hf1 ();
  hazard_forward_if #(.REG_ADDR_W(AW), .CNT_W(2))  hf2 ();

  assign hf0.freeze = freeze; assign hf0.flush = flush; assign hf0.src1 = src1; assign hf0.src2 = src2;
  assign hf0.is_single_src = is_single_src; assign hf0.is_BNE = is_BNE; assign hf0.Exe_Dest = Exe_Dest;
  assign hf0.Exe_WB_EN = Exe_WB_EN; assign hf0.Exe_MEM_R_EN = Exe_MEM_R_EN; assign hf0.Mem_Dest = Mem_Dest;
  assign hf0.Mem_WB_EN = Mem_WB_EN; assign hf0.WB_Dest = WB_Dest; assign hf0.WB_WB_EN = WB_WB_EN;

  assign hf1.freeze = freeze; assign hf1.flush = flush; assign hf1.src1 = src1; assign hf1.src2 = src2;
  assign hf1.is_single_src = is_single_src; assign hf1.is_BNE = is_BNE; assign hf1.Exe_Dest = Exe_Dest;
  assign hf1.Exe_WB_EN = Exe_WB_EN; assign hf1.Exe_MEM_R_EN = Exe_MEM_R_EN; assign hf1.Mem_Dest = Mem_Dest;
  assign hf1.Mem_WB_EN = Mem_WB_EN; assign hf1.WB_Dest = WB_Dest; assign hf1.WB_WB_EN = WB_WB_EN;

  assign hf2.freeze = freeze; assign hf2.flush = flush; assign hf2.src1 = src1; assign hf2.src2 = src2;
  assign hf2.is_single_src = is_single_src; assign hf2.is_BNE = is_BNE; assign hf2.Exe_Dest = Exe_Dest;
  assign hf2.Exe_WB_EN = Exe_WB_EN; assign hf2.Exe_MEM_R_EN = Exe_MEM_R_EN; assign hf2.Mem_Dest = Mem_Dest;
  assign hf2.Mem_WB_EN = Mem_WB_EN; assign hf2.WB_Dest = WB_Dest; assign hf2.WB_WB_EN = WB_WB_EN;

  hazard_forward_unit #(.REG_ADDR_W(AW), .FORWARD_EN(1), .LOAD_STALL(3), .CNT_W(16))
    u_fwd (.clk(clk), .rst(rst), .bus(hf0));
  hazard_forward_unit #(.REG_ADDR_W(AW), .FORWARD_EN(0), .LOAD_STALL(1), .CNT_W(16))
    u_nofwd (.clk(clk), .rst(rst), .bus(hf1));
  hazard_forward_unit #(.REG_ADDR_W(AW), .FORWARD_EN(1), .LOAD_STALL(2), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .bus(hf2));

  logic        obs_haz [3];
  logic [1:0]  obs_f1  [3];
  logic [1:0]  obs_f2  [3];
  logic [15:0] obs_cnt [3];
  assign obs_haz[0] = hf0.hazard_Detected; assign obs_f1[0] = hf0.fwd_sel_src1;
  assign obs_f2[0]  = hf0.fwd_sel_src2;    assign obs_cnt[0] = hf0.stall_count;
  assign obs_haz[1] = hf1.hazard_Detected; assign obs_f1[1] = hf1.fwd_sel_src1;
  assign obs_f2[1]  = hf1.fwd_sel_src2;    assign obs_cnt[1] = hf1.stall_count;
  assign obs_haz[2] = hf2.hazard_Detected; assign obs_f1[2] = hf2.fwd_sel_src1;
  assign obs_f2[2]  = hf2.fwd_sel_src2;    assign obs_cnt[2] = {14'b0, hf2.stall_count};

  // Per-instance parameters and model state.
  int p_fe   [3] = '{1, 0, 1};
  int p_ls   [3] = '{3, 1, 2};
  int p_cmax [3] = '{65535, 65535, 3};
  int m_stall [3] = '{0, 0, 0};
  int m_e1    [3] = '{0, 0, 0};
  int m_e2    [3] = '{0, 0, 0};
  int m_u2    [3] = '{0, 0, 0};
  int m_cnt   [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;
  int haz_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input int r, input int d, input logic en);
    return (r != 0) && (r == d) && (en === 1'b1);
  endfunction

  // One clock cycle: inputs are already set; check all instances, then advance the model.
  task automatic step();
    bit u2, me, mm, lu, det, haz;
    int f1, f2;
    #1;
    if (obs_haz[0] === 1'b1) haz_seen++;
    for (int k = 0; k < 3; k++) begin
      u2  = is_BNE || !is_single_src;
      me  = dep(src1, Exe_Dest, Exe_WB_EN) || (u2 && dep(src2, Exe_Dest, Exe_WB_EN));
      mm  = dep(src1, Mem_Dest, Mem_WB_EN) || (u2 && dep(src2, Mem_Dest, Mem_WB_EN));
      lu  = me && Exe_MEM_R_EN;
      det = (p_fe[k] != 0) ? (lu || (is_BNE && (me || mm))) : (me || mm);
      haz = rst && !flush && (det || m_stall[k] > 0);
      f1 = 0;
      f2 = 0;
      if (p_fe[k] != 0) begin
        if (dep(m_e1[k], Mem_Dest, Mem_WB_EN)) f1 = 1;
        else if (dep(m_e1[k], WB_Dest, WB_WB_EN)) f1 = 2;
        if (m_u2[k] != 0) begin
          if (dep(m_e2[k], Mem_Dest, Mem_WB_EN)) f2 = 1;
          else if (dep(m_e2[k], WB_Dest, WB_WB_EN)) f2 = 2;
        end
      end
      chk($sformatf("hazard[%0d]", k), obs_haz[k], int'(haz));
      chk($sformatf("fwd1[%0d]", k), obs_f1[k], f1);
      chk($sformatf("fwd2[%0d]", k), obs_f2[k], f2);
      chk($sformatf("count[%0d]", k), obs_cnt[k], m_cnt[k]);

      if (!rst) begin
        m_stall[k] = 0; m_e1[k] = 0; m_e2[k] = 0; m_u2[k] = 0; m_cnt[k] = 0;
      end else begin
        if (haz && !freeze && m_cnt[k] < p_cmax[k]) m_cnt[k]++;
        if (flush) m_stall[k] = 0;
        else if (!freeze) begin
          if (m_stall[k] > 0) m_stall[k]--;
          else if (lu && p_ls[k] > 1) m_stall[k] = p_ls[k] - 1;
        end
        if (!freeze) begin
          if (flush || haz) begin
            m_e1[k] = 0; m_e2[k] = 0; m_u2[k] = 0;
          end else begin
            m_e1[k] = src1; m_e2[k] = src2; m_u2[k] = u2;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; is_single_src = 1'b1; is_BNE = 1'b0;
    src1 = '0; src2 = '0; Exe_Dest = '0; Mem_Dest = '0; WB_Dest = '0;
    Exe_WB_EN = 1'b0; Exe_MEM_R_EN = 1'b0; Mem_WB_EN = 1'b0; WB_WB_EN = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with a load-use and branch dependence present.
    src1 = 5'd3; Exe_Dest = 5'd3; Exe_WB_EN = 1'b1; Exe_MEM_R_EN = 1'b1; is_BNE = 1'b1;
    step();
    step();
    chk("rst_cnt", obs_cnt[0], 0);

    // Stall-always mode on a plain RAW, then register 0.
    idle_inputs();
    src1 = 5'd3; src2 = 5'd4; is_single_src = 1'b0; Exe_Dest = 5'd4; Exe_WB_EN = 1'b1;
    #1 chk("nofwd_raw", obs_haz[1], 1);
    chk("fwd_raw_nostall", obs_haz[0], 0);
    step();
    src1 = 5'd0; Exe_Dest = 5'd0;
    #1 chk("nofwd_r0", obs_haz[1], 0);
    step();

    // Three-cycle load-use stall.
    do_reset();
    src1 = 5'd5; Exe_Dest = 5'd5; Exe_WB_EN = 1'b1; Exe_MEM_R_EN = 1'b1;
    haz_seen = 0;
    step();
    Exe_WB_EN = 1'b0; Exe_MEM_R_EN = 1'b0; Mem_Dest = 5'd5; Mem_WB_EN = 1'b1;
    step();
    step();
    Mem_WB_EN = 1'b0; WB_Dest = 5'd5; WB_WB_EN = 1'b1;
    step();
    chk("ls_len", haz_seen, 3);
    chk("ls_cnt", obs_cnt[0], 3);

    // Same stall with a freeze in its second cycle.
    do_reset();
    src1 = 5'd5; Exe_Dest = 5'd5; Exe_WB_EN = 1'b1; Exe_MEM_R_EN = 1'b1;
    haz_seen = 0;
    step();
    Exe_WB_EN = 1'b0; Exe_MEM_R_EN = 1'b0; Mem_Dest = 5'd5; Mem_WB_EN = 1'b1; freeze = 1'b1;
    step();
    freeze = 1'b0;
    step();
    step();
    Mem_WB_EN = 1'b0; WB_Dest = 5'd5; WB_WB_EN = 1'b1;
    step();
    chk("ls_frz_len", haz_seen, 4);
    chk("ls_frz_cnt", obs_cnt[0], 3);

    // Forwarding select: MEM over WB, then WB alone.
    do_reset();
    src1 = 5'd7;
    step();
    src1 = 5'd0; Mem_Dest = 5'd7; Mem_WB_EN = 1'b1; WB_Dest = 5'd7; WB_WB_EN = 1'b1;
    #1 chk("fwd_mem", obs_f1[0], 1);
    chk("nofwd_sel", obs_f1[1], 0);
    step();
    src1 = 5'd7; Mem_WB_EN = 1'b0; WB_WB_EN = 1'b0;
    step();
    src1 = 5'd0; WB_WB_EN = 1'b1;
    #1 chk("fwd_wb", obs_f1[0], 2);
    step();

    // Branch operand dependence, then flush in the same cycle.
    do_reset();
    is_BNE = 1'b1; src2 = 5'd9; Mem_Dest = 5'd9; Mem_WB_EN = 1'b1;
    #1 chk("bne_haz", obs_haz[0], 1);
    flush = 1'b1;
    #1 chk("bne_flush", obs_haz[0], 0);
    step();
    flush = 1'b0; is_BNE = 1'b0; src2 = 5'd0;
    #1 chk("bne_exe_clr", obs_f2[0], 0);
    chk("bne_cnt", obs_cnt[0], 0);
    step();

    // Counter saturation on the 2-bit instance.
    do_reset();
    is_BNE = 1'b1; src1 = 5'd2; Exe_Dest = 5'd2; Exe_WB_EN = 1'b1;
    repeat (6) step();
    chk("sat_cnt", obs_cnt[2], 3);
    chk("wide_cnt", obs_cnt[0], 6);

    // Randomized traffic over a small register window to provoke frequent matches.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(63) != 0);
      freeze        = ($urandom_range(7) == 0);
      flush         = ($urandom_range(9) == 0);
      is_single_src = 1'($urandom_range(1));
      is_BNE        = ($urandom_range(5) == 0);
      src1          = 5'($urandom_range(7));
      src2          = 5'($urandom_range(7));
      Exe_Dest      = 5'($urandom_range(7));
      Mem_Dest      = 5'($urandom_range(7));
      WB_Dest       = 5'($urandom_range(7));
      Exe_WB_EN     = 1'($urandom_range(1));
      Exe_MEM_R_EN  = ($urandom_range(2) == 0);
      Mem_WB_EN     = 1'($urandom_range(1));
      WB_WB_EN      = 1'($urandom_range(1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
